// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit AND/OR/XOR logic unit.
// Optional LU_STATS_EN adds a saturating completed-response counter (stat_done).
`timescale 1ns/1ps

module logic_unit_arbiter #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic             lu_f0,
  output logic             lu_f1,
  input  logic [WIDTH-1:0] lu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
`ifdef LU_STATS_EN
  ,
  output logic [15:0]      stat_done
`endif
);

  // state  | meaning
  // IDLE   | arbitrating, readies live, unit inputs hold last op
  // SETTLE | operands on the unit, counting down to capture
  // RESP   | result held on rsp_* until the consumer takes it
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   count;
  logic            last_grant;
  logic            grant_any;
  logic            grant_id;
  logic            accept;
  logic            settle_done;
  logic            rsp_fire;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [1:0]      sel_op;

  // Tie goes to whichever requester did not win last time.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = ~req0_valid;
    end
    sel_a  = grant_id ? req1_a  : req0_a;
    sel_b  = grant_id ? req1_b  : req0_b;
    sel_op = grant_id ? req1_op : req0_op;
  end

  assign accept      = (state == ST_IDLE) && grant_any;
  assign settle_done = (state == ST_SETTLE) && (count == CW'(1));
  assign rsp_fire    = (state == ST_RESP) && rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept)      state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_nxt = ST_RESP;
      ST_RESP:   if (rsp_fire)    state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (accept) begin
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_a       <= '0;
      lu_b       <= '0;
      lu_f0      <= 1'b0;
      lu_f1      <= 1'b0;
      count      <= '0;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
    end else if (accept) begin
      lu_a       <= sel_a;
      lu_b       <= sel_b;
      lu_f0      <= sel_op[1];
      lu_f1      <= sel_op[0];
      count      <= CW'(SETTLE_CYCLES);
      last_grant <= grant_id;
      rsp_id     <= grant_id;
    end else if ((state == ST_SETTLE) && !settle_done) begin
      count <= count - CW'(1);
    end
  end

  // The unit is purely combinational; its output is sampled once the settle window expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (settle_done) begin
      rsp_valid <= 1'b1;
      rsp_data  <= lu_out;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef LU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_done <= '0;
    end else if (rsp_fire && (stat_done != 16'hFFFF)) begin
      stat_done <= stat_done + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps

module tb_logic_unit_arbiter;
  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] lu_a, lu_b, lu_out, rsp_data;
  logic         lu_f0, lu_f1, rsp_valid, rsp_id;
  logic         rsp_ready = 1'b0;
`ifdef LU_STATS_EN
  logic [15:0]  stat_done;
`endif

  int tests = 0;
  int fails = 0;

  logic_unit_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .lu_a(lu_a), .lu_b(lu_b), .lu_f0(lu_f0), .lu_f1(lu_f1), .lu_out(lu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef LU_STATS_EN
    , .stat_done(stat_done)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] lu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
    case (op)
      2'b01:   return a & b;
      2'b10:   return a | b;
      2'b11:   return a ^ b;
      default: return '0;
    endcase
  endfunction

  // The shared gate-level unit
  assign lu_out = lu_fn(lu_a, lu_b, {lu_f0, lu_f1});

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one op in flight, response due S edges after accept
  bit           m_busy = 0;
  logic         m_valid = 0;
  logic [W-1:0] m_data = '0, m_pend = '0, m_la = '0, m_lb = '0;
  logic [1:0]   m_lop = '0;
  logic         m_id = 0, m_last = 1;
  int           cyc = 0, m_due = 0, m_stats = 0;

  function automatic logic winner(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1 && !v0;
  endfunction

  initial begin : model
    logic g;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_valid = 0; m_data = '0; m_pend = '0; m_la = '0; m_lb = '0;
        m_lop = '0; m_id = 0; m_last = 1; m_stats = 0;
      end else begin
        cyc++;
        if (!m_busy) begin
          if (req0_valid || req1_valid) begin
            g      = winner(req0_valid, req1_valid, m_last);
            m_la   = g ? req1_a : req0_a;
            m_lb   = g ? req1_b : req0_b;
            m_lop  = g ? req1_op : req0_op;
            m_pend = lu_fn(m_la, m_lb, m_lop);
            m_id   = g;
            m_last = g;
            m_busy = 1;
            m_due  = cyc + S;
          end
        end else if (m_valid) begin
          if (rsp_ready) begin
            m_valid = 0;
            m_busy  = 0;
            if (m_stats < 65535) m_stats++;
          end
        end else if (cyc == m_due) begin
          m_valid = 1;
          m_data  = m_pend;
        end
      end
    end
  end

  initial begin : compare
    logic g, e0, e1;
    forever begin
      @(negedge clk);
      g  = winner(req0_valid, req1_valid, m_last);
      e0 = !m_busy && req0_valid && !g;
      e1 = !m_busy && req1_valid && g;
      chk("req0_ready", W'(req0_ready), W'(e0));
      chk("req1_ready", W'(req1_ready), W'(e1));
      chk("rsp_valid", W'(rsp_valid), W'(m_valid));
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_id", W'(rsp_id), W'(m_id));
      chk("lu_a", lu_a, m_la);
      chk("lu_b", lu_b, m_lb);
      chk("lu_op", W'({lu_f0, lu_f1}), W'(m_lop));
`ifdef LU_STATS_EN
      chk("stat_done", W'(stat_done), W'(m_stats));
`endif
    end
  end

  task automatic drive_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op);
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end
  endtask

  // Present a request and hold it until accepted; returns just after the accept edge
  task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op);
    bit ok;
    ok = 0;
    drive_req(id, a, b, op);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin
        @(posedge clk); #1;
        ok = 1;
      end
    end
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, got;
    logic [1:0]   ops [3] = '{2'b10, 2'b11, 2'b00};
    logic [W-1:0] exps[3] = '{32'd62, 32'd54, 32'd0};

    repeat (3) @(posedge clk);
    #1 chk("reset_rsp_valid", W'(rsp_valid), 0);
    chk("reset_lu_a", lu_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: req0 AND
    rsp_ready = 1'b1;
    send(0, 32'd30, 32'd40, 2'b01);
    wait_rsp(n);
    chk("t1_latency", n, S);
    chk("t1_data", rsp_data, 32'd8);
    chk("t1_id", W'(rsp_id), 0);
    @(posedge clk); #1;
    chk("t1_rsp_cleared", W'(rsp_valid), 0);

    // 2: req1 OR / XOR / zero
    for (int k = 0; k < 3; k++) begin
      send(1, 32'd30, 32'd40, ops[k]);
      wait_rsp(n);
      chk("t2_data", rsp_data, exps[k]);
      chk("t2_id", W'(rsp_id), 1);
      @(posedge clk); #1;
    end
`ifdef LU_STATS_EN
    chk("t6_stat_after_4", W'(stat_done), 4);
`endif

    // 3: both always valid -> alternate starting with req0
    drive_req(0, 32'd1, 32'd3, 2'b01);
    drive_req(1, 32'd2, 32'd3, 2'b11);
    for (int k = 0; k < 4; k++) begin
      got = -1;
      for (int i = 0; i < 20 && got < 0; i++) begin
        @(negedge clk);
        if (req0_ready) got = 0;
        else if (req1_ready) got = 1;
      end
      chk("t3_grant", W'(got), W'(k % 2));
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) @(posedge clk); #1;

    // 4: consumer stall
    rsp_ready = 1'b0;
    send(0, 32'd5, 32'd3, 2'b11);
    wait_rsp(n);
    drive_req(1, 32'hF0, 32'h0F, 2'b10);
    repeat (5) begin
      @(negedge clk);
      chk("t4_valid_held", W'(rsp_valid), 1);
      chk("t4_data_held", rsp_data, 32'd6);
      chk("t4_id_held", W'(rsp_id), 0);
      chk("t4_ready1_low", W'(req1_ready), 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_accept_after", W'(req1_ready), 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    repeat (6) @(posedge clk); #1;

    // 5: reset in SETTLE
    send(0, 32'd7, 32'd9, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", W'(rsp_valid), 0);
    chk("t5_rsp_data", rsp_data, 0);
    chk("t5_rsp_id", W'(rsp_id), 0);
    chk("t5_lu_a", lu_a, 0);
    chk("t5_lu_b", lu_b, 0);
    chk("t5_lu_op", W'({lu_f0, lu_f1}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("t5_no_rsp", W'(rsp_valid), 0);
    end

    // Random traffic
    repeat (400) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = $urandom; req0_b = $urandom; req0_op = 2'($urandom_range(0, 3));
      req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
